// File: rtl/wfq_ftime_scanner.sv
// rtl/wfq_ftime_scanner.sv - WFQ finish-time RAM minimum scanner with optional pop
//
// Purpose:
//   Sweeps entries 0..L-1 of the finish-time RAM through its registered read
//   port and reports the entry holding the smallest non-zero finish time.
//   A zero finish time marks an empty slot. Optionally clears the winning
//   entry through the RAM write port so the flow is dequeued.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle scan request, honoured only while busy=0
//   scan_len [N:0]      number of entries to scan (clamped to 2**N)
//   pop_en              clear the winning entry at the end of the scan
//   r_addr   [N-1:0]    RAM read address (registered)
//   rd_data  [N+2:0]    RAM dout, valid the cycle after r_addr is captured
//   we, w_addr, wdata   RAM write port (wdata is always 0)
//   busy                high from the cycle after start until the done cycle
//   done                one-cycle pulse, results valid on this cycle
//   found, min_addr, min_ftime   scan result, held until the next start

module wfq_ftime_scanner #(
  parameter int N = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N:0]   scan_len,
  input  logic         pop_en,
  output logic [N-1:0] r_addr,
  input  logic [N+2:0] rd_data,
  output logic         we,
  output logic [N-1:0] w_addr,
  output logic [N+2:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [N-1:0] min_addr,
  output logic [N+2:0] min_ftime
);

  localparam logic [N:0] DEPTH = {1'b1, {N{1'b0}}};
  localparam logic [N:0] ONE   = {{N{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [N:0]   len_c;       // clamped scan length
  logic [N:0]   last_idx;    // index of the last address to issue
  logic [N:0]   cnt;         // next address to issue; N+1 bits so 2**N fits
  logic         pop_q;
  logic         accept;
  logic         issue;
  logic         v1;          // address on r_addr is a real scan address
  logic         v2;          // rd_data holds a real scan entry
  logic [N-1:0] cmp_addr;    // address whose data is on rd_data now
  logic         upd;
  logic         found_nx;
  logic [N-1:0] addr_nx;

  assign wdata = '0;

  // busy is 0 only in IDLE outside the trailing done cycle
  assign accept = start && !busy && (state == IDLE);
  assign len_c  = (scan_len > DEPTH) ? DEPTH : scan_len;

  // New minimum: strict less-than keeps the lowest address on ties
  assign upd = v2 && (rd_data != '0) && (!found || (rd_data < min_ftime));
  assign found_nx = upd ? 1'b1 : found;
  assign addr_nx  = upd ? cmp_addr : min_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address 0 is issued on the accepting edge itself, so SCAN covers
  // addresses 1..L-1; a one-entry scan goes straight to DRAIN.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (len_c == '0) begin
            state_next = FIN;
          end else if (len_c == ONE) begin
            state_next = DRAIN;
            issue      = 1'b1;
          end else begin
            state_next = SCAN;
            issue      = 1'b1;
          end
        end
      end
      SCAN: begin
        issue = 1'b1;
        if (cnt == last_idx) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = FIN;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address issue and compare pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      cnt      <= '0;
      last_idx <= '0;
      pop_q    <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      cmp_addr <= '0;
    end else begin
      v1       <= issue;
      v2       <= v1;
      cmp_addr <= r_addr;
      if (accept) begin
        r_addr   <= '0;
        cnt      <= ONE;
        last_idx <= len_c - ONE;
        pop_q    <= pop_en;
      end else if (state == SCAN) begin
        r_addr <= cnt[N-1:0];
        cnt    <= cnt + ONE;
      end else begin
        // Wraps back to 0 once the last address has been issued
        r_addr <= '0;
      end
    end
  end

  // Results, handshake and pop write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      min_addr  <= '0;
      min_ftime <= '0;
      we        <= 1'b0;
      w_addr    <= '0;
    end else begin
      // The final entry is compared on the FIN edge, so done and we are
      // raised on that same edge using the post-compare winner.
      done <= (state == FIN);
      if (accept) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end

      if (accept) begin
        found     <= 1'b0;
        min_addr  <= '0;
        min_ftime <= '0;
      end else if (upd) begin
        found     <= 1'b1;
        min_addr  <= cmp_addr;
        min_ftime <= rd_data;
      end

      if ((state == FIN) && pop_q && found_nx) begin
        we     <= 1'b1;
        w_addr <= addr_nx;
      end else begin
        we     <= 1'b0;
        w_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wfq_ftime_scanner.sv
// tb/tb_wfq_ftime_scanner.sv - directed self-checking bench for wfq_ftime_scanner
module tb_wfq_ftime_scanner;
  localparam int N = 13;
  localparam int DEPTH = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N:0]   scan_len = '0;
  logic         pop_en = 1'b0;
  logic [N-1:0] r_addr;
  logic [N+2:0] rd_data = '0;
  logic         we;
  logic [N-1:0] w_addr;
  logic [N+2:0] wdata;
  logic         busy;
  logic         done;
  logic         found;
  logic [N-1:0] min_addr;
  logic [N+2:0] min_ftime;

  logic [N+2:0] mem [0:DEPTH-1];

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int lat;

  wfq_ftime_scanner #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scan_len(scan_len),
    .pop_en(pop_en), .r_addr(r_addr), .rd_data(rd_data), .we(we),
    .w_addr(w_addr), .wdata(wdata), .busy(busy), .done(done),
    .found(found), .min_addr(min_addr), .min_ftime(min_ftime)
  );

  always #5 clk = ~clk;

  // Finish-time RAM model: registered read, write port from the scanner
  always @(posedge clk) begin
    rd_data <= mem[r_addr];
    if (we) mem[w_addr] <= wdata;
  end

  always @(negedge clk) begin
    if (we === 1'b1) we_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  // Presents start on a negedge; returns edges from the start edge to done
  task automatic run_scan(input int len, input logic pop, output int l);
    @(negedge clk);
    start = 1'b1;
    scan_len = (N+1)'(len);
    pop_en = pop;
    @(posedge clk);
    #1;
    start = 1'b0;
    l = 0;
    while (done !== 1'b1 && l < 20000) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_we"}, 32'(we), 0);
    check({tag, "_found"}, 32'(found), 0);
    check({tag, "_min_addr"}, 32'(min_addr), 0);
    check({tag, "_min_ftime"}, 32'(min_ftime), 0);
    check({tag, "_r_addr"}, 32'(r_addr), 0);
  endtask

  initial begin
    clear_mem();
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic minimum
    mem[0] = 0; mem[1] = 40; mem[2] = 12; mem[3] = 0;
    mem[4] = 99; mem[5] = 12; mem[6] = 7; mem[7] = 30;
    we_cnt = 0;
    run_scan(8, 1'b0, lat);
    check("basic_latency", 32'(lat), 9);
    check("basic_found", 32'(found), 1);
    check("basic_min_addr", 32'(min_addr), 6);
    check("basic_min_ftime", 32'(min_ftime), 7);
    check("basic_busy_in_done", 32'(busy), 1);
    repeat (3) @(posedge clk);
    #1;
    check("basic_no_we", 32'(we_cnt), 0);
    check("basic_hold_addr", 32'(min_addr), 6);

    // Tie and pop, then rescan in the first idle cycle
    clear_mem();
    mem[0] = 5; mem[1] = 0; mem[2] = 5; mem[3] = 9;
    run_scan(4, 1'b1, lat);
    check("tie_latency", 32'(lat), 5);
    check("tie_min_addr", 32'(min_addr), 0);
    check("tie_min_ftime", 32'(min_ftime), 5);
    check("pop_we", 32'(we), 1);
    check("pop_w_addr", 32'(w_addr), 0);
    check("pop_wdata", 32'(wdata), 0);
    @(posedge clk);
    #1;
    check("tie_busy_fall", 32'(busy), 0);
    check("tie_we_fall", 32'(we), 0);
    run_scan(4, 1'b0, lat);
    check("rescan_latency", 32'(lat), 5);
    check("rescan_min_addr", 32'(min_addr), 2);
    check("rescan_min_ftime", 32'(min_ftime), 5);

    // Empty RAM with pop, then zero length
    clear_mem();
    repeat (2) @(posedge clk);
    we_cnt = 0;
    run_scan(16, 1'b1, lat);
    check("empty_latency", 32'(lat), 17);
    check("empty_found", 32'(found), 0);
    check("empty_min_addr", 32'(min_addr), 0);
    check("empty_min_ftime", 32'(min_ftime), 0);
    check("empty_we", 32'(we), 0);
    repeat (2) @(posedge clk);
    run_scan(0, 1'b1, lat);
    check("zero_latency", 32'(lat), 1);
    check("zero_found", 32'(found), 0);
    check("zero_we", 32'(we), 0);
    repeat (2) @(posedge clk);
    #1;
    check("empty_zero_no_we", 32'(we_cnt), 0);

    // Full range with clamp
    mem[DEPTH-1] = 3;
    run_scan(DEPTH + 5, 1'b0, lat);
    check("full_latency", 32'(lat), DEPTH + 1);
    check("full_min_addr", 32'(min_addr), DEPTH - 1);
    check("full_min_ftime", 32'(min_ftime), 3);
    check("full_r_addr_wrap", 32'(r_addr), 0);

    // start while busy is ignored and does not re-sample
    repeat (2) @(posedge clk);
    mem[3] = 20;
    done_cnt = 0;
    we_cnt = 0;
    @(negedge clk);
    start = 1'b1; scan_len = (N+1)'(8); pop_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; scan_len = '0; pop_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("busy_single_done", 32'(done_cnt), 1);
    check("busy_found", 32'(found), 1);
    check("busy_min_addr", 32'(min_addr), 3);
    check("busy_no_we", 32'(we_cnt), 0);

    // Reset mid-scan
    @(negedge clk);
    start = 1'b1; scan_len = (N+1)'(16); pop_en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_r_addr", 32'(r_addr), 5);
    check("mid_found", 32'(found), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    we_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_no_we", 32'(we_cnt), 0);

    // Fresh scan after reset
    run_scan(16, 1'b1, lat);
    check("fresh_latency", 32'(lat), 17);
    check("fresh_min_addr", 32'(min_addr), 3);
    check("fresh_min_ftime", 32'(min_ftime), 20);
    check("fresh_we", 32'(we), 1);
    check("fresh_w_addr", 32'(w_addr), 3);
    @(posedge clk);
    #1;
    check("fresh_mem_cleared", 32'(mem[3]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
